// File: rtl/mux_rr_stage_if.sv
// ============================================================================
// Module  : mux_rr_stage_if
// Brief   : Source/mux/downstream signal bundle for the round-robin mux stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mux_rr_stage_if #(
    parameter int WIDTH = 8
);
    logic             A_valid;
    logic             A_ready;
    logic             B_valid;
    logic             B_ready;
    logic             SEL;
    logic [WIDTH-1:0] mux_output;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;

    // Stage side
    modport slave (
        input  A_valid,
        input  B_valid,
        input  mux_output,
        input  out_ready,
        output A_ready,
        output B_ready,
        output SEL,
        output out_data,
        output out_src,
        output out_valid
    );

    // Environment side: sources, the mux and the downstream consumer
    modport master (
        output A_valid,
        output B_valid,
        output mux_output,
        output out_ready,
        input  A_ready,
        input  B_ready,
        input  SEL,
        input  out_data,
        input  out_src,
        input  out_valid
    );
endinterface

`default_nettype wire

// File: rtl/mux_rr_stage.sv
// ============================================================================
// Module  : mux_rr_stage
// Brief   : Round-robin arbiter driving a 2:1 mux SEL, with a one-slot
//           registered output under valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_rr_stage #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_rr_stage_if.slave    bus
);

    logic             last_grant_q, last_grant_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             out_src_q,    out_src_d;

    logic sel;
    logic can_accept;
    logic a_ready;
    logic b_ready;
    logic fire;

    // Under contention the source not served most recently wins.
    always_comb begin
        sel = 1'b0;
        if (bus.A_valid && bus.B_valid) begin
            sel = ~last_grant_q;
        end else if (bus.B_valid) begin
            sel = 1'b1;
        end
    end

    assign can_accept = !out_valid_q || bus.out_ready;
    assign a_ready    = !rst && can_accept && !sel;
    assign b_ready    = !rst && can_accept &&  sel;
    assign fire       = (bus.A_valid && a_ready) || (bus.B_valid && b_ready);

    // A fire coinciding with a downstream pop simply overwrites the slot.
    always_comb begin
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        if (fire) begin
            out_data_d   = bus.mux_output;
            out_src_d    = sel;
            out_valid_d  = 1'b1;
            last_grant_d = sel;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign bus.SEL       = sel;
    assign bus.A_ready   = a_ready;
    assign bus.B_ready   = b_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_stage.sv
// ============================================================================
// Module  : tb_mux_rr_stage
// Brief   : Directed and randomized self-checking bench for mux_rr_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_stage;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;

    int checks = 0;
    int errors = 0;

    // Reference state: contents of the single output slot and who was served last
    logic             m_full;
    logic [WIDTH-1:0] m_data;
    logic             m_src;
    logic             m_last;
    logic             m_fa;
    logic             m_fb;

    mux_rr_stage_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_stage #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The mux itself lives outside the stage
    assign bus.mux_output = bus.SEL ? in_B : in_A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake outputs mid-cycle, then the registered slot.
    task automatic step(input string tag);
        logic want_b;
        logic can;
        logic ea, eb;
        @(negedge clk);
        if (bus.A_valid && bus.B_valid) want_b = (m_last == 1'b0);
        else                            want_b = bus.B_valid;
        can = !m_full || bus.out_ready;
        ea  = !rst && can && !want_b;
        eb  = !rst && can &&  want_b;
        chk({tag, "_sel"},    32'(bus.SEL),     32'(want_b));
        chk({tag, "_aready"}, 32'(bus.A_ready), 32'(ea));
        chk({tag, "_bready"}, 32'(bus.B_ready), 32'(eb));
        m_fa = bus.A_valid && ea;
        m_fb = bus.B_valid && eb;
        @(posedge clk);
        #1;
        if (rst) begin
            m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        end else if (m_fa || m_fb) begin
            m_full = 1'b1;
            m_src  = m_fb;
            m_data = m_fb ? in_B : in_A;
            m_last = m_fb;
        end else if (bus.out_ready) begin
            m_full = 1'b0;
        end
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'(m_full));
        chk({tag, "_odata"},  32'(bus.out_data),  32'(m_data));
        chk({tag, "_osrc"},   32'(bus.out_src),   32'(m_src));
    endtask

    task automatic drive(input logic av, input logic [7:0] a, input logic bv,
                         input logic [7:0] b, input logic ordy);
        bus.A_valid   = av;
        in_A          = a;
        bus.B_valid   = bv;
        in_B          = b;
        bus.out_ready = ordy;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step("rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h11; seq[3] = 8'h22;
        m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        m_fa = 1'b0; m_fb = 1'b0;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;

        // 1: reset state
        do_reset(2);
        chk("t1_ovalid", 32'(bus.out_valid), 32'(1'b0));
        chk("t1_odata",  32'(bus.out_data),  32'(8'h00));
        chk("t1_osrc",   32'(bus.out_src),   32'(1'b0));
        #1;
        chk("t1_sel",    32'(bus.SEL),       32'(1'b0));
        chk("t1_aready", 32'(bus.A_ready),   32'(1'b1));

        // 2: single A transfer
        drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        step("t2");
        chk("t2_word", 32'(bus.out_data), 32'(8'h3C));
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step("t2_idle");

        // 3: continuous contention alternates, A first
        do_reset(2);
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("t3");
            chk("t3_seq", 32'(bus.out_data), 32'(seq[i]));
            chk("t3_full", 32'(bus.out_valid), 32'(1'b1));
        end

        // 4: stall holds the slot, release lets the waiting word in
        do_reset(1);
        drive(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        step("t4_fill");
        drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("t4_stall");
            chk("t4_hold", 32'(bus.out_data), 32'(8'hAA));
        end
        bus.out_ready = 1'b1;
        step("t4_release");
        chk("t4_new", 32'(bus.out_data), 32'(8'h55));

        // 5: B-only burst, then contention goes to A
        do_reset(1);
        drive(1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_B = 8'hB0 + 8'(i);
            step("t5_b");
        end
        drive(1'b1, 8'hA5, 1'b1, 8'hB5, 1'b1);
        step("t5_contend");
        chk("t5_winner", 32'(bus.out_src), 32'(1'b0));

        // 6: reset while holding a stalled word
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        step("t6_fill");
        rst = 1'b1;
        step("t6_rst");
        rst = 1'b0;
        chk("t6_empty", 32'(bus.out_valid), 32'(1'b0));

        // Randomized traffic; sources hold valid/data until accepted
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (!bus.A_valid || m_fa) begin
                bus.A_valid = 1'($urandom_range(0, 1));
                in_A        = 8'($urandom);
            end
            if (!bus.B_valid || m_fb) begin
                bus.B_valid = 1'($urandom_range(0, 1));
                in_B        = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
